// File: rtl/ika87ad_pkg.sv
// Shared IKA87AD definitions: prefix bytes, opcode page encodings, the HARDI
// pseudo-opcode and the opcode-fetch state enum.
package ika87ad_pkg;

    localparam logic [7:0] PFX_48 = 8'h48;
    localparam logic [7:0] PFX_60 = 8'h60;
    localparam logic [7:0] PFX_64 = 8'h64;
    localparam logic [7:0] PFX_70 = 8'h70;
    localparam logic [7:0] PFX_74 = 8'h74;

    localparam logic [2:0] PAGE_0 = 3'd0;
    localparam logic [2:0] PAGE_1 = 3'd1;
    localparam logic [2:0] PAGE_2 = 3'd2;
    localparam logic [2:0] PAGE_3 = 3'd3;
    localparam logic [2:0] PAGE_4 = 3'd4;
    localparam logic [2:0] PAGE_5 = 3'd5;

    localparam logic [7:0] OP_HARDI = 8'h73;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_PFX  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    // Returns {is_prefix, page}; non-prefix bytes map to page 0.
    function automatic logic [3:0] pfx_to_page(input logic [7:0] b);
        logic [3:0] r;
        case (b)
            PFX_48:  r = {1'b1, PAGE_1};
            PFX_60:  r = {1'b1, PAGE_2};
            PFX_64:  r = {1'b1, PAGE_3};
            PFX_70:  r = {1'b1, PAGE_4};
            PFX_74:  r = {1'b1, PAGE_5};
            default: r = {1'b0, PAGE_0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ika87ad_opfetch.sv
// Opcode fetch / prefix sequencer: turns the prefetch byte stream into a
// registered {page, opcode} for the decoder and injects HARDI at boundaries.
module ika87ad_opfetch
    import ika87ad_pkg::*;
(
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_FLUSH,
    input  logic [7:0] i_BYTE,
    input  logic       i_BYTE_VALID,
    output logic       o_BYTE_READY,
    input  logic       i_IRQ_PEND,
    output logic       o_IRQ_TAKEN,
    output logic [7:0] o_OPCODE,
    output logic [2:0] o_OPCODE_PAGE,
    output logic       o_OP_VALID,
    input  logic       i_OP_READY,
    output logic       o_OP_INJECTED,
    output logic       o_BOUNDARY
);

    // Byte handshake: a byte is consumed on a rising edge where
    // i_BYTE_VALID && o_BYTE_READY; an opcode is consumed where
    // o_OP_VALID && i_OP_READY. Neither side may retract a raised valid.

    fetch_state_e state, state_n;
    logic [2:0]   pfx_page, pfx_page_n;
    logic         load;
    logic [7:0]   load_opcode;
    logic [2:0]   load_page;
    logic         load_injected;
    logic [3:0]   pfx_info;

    assign pfx_info = pfx_to_page(i_BYTE);

    always_comb begin
        state_n       = state;
        pfx_page_n    = pfx_page;
        o_BYTE_READY  = 1'b0;
        o_IRQ_TAKEN   = 1'b0;
        load          = 1'b0;
        load_opcode   = i_BYTE;
        load_page     = PAGE_0;
        load_injected = 1'b0;

        if (i_RST) begin
            state_n = FETCH_IDLE;
        end else if (i_FLUSH) begin
            state_n    = FETCH_IDLE;
            pfx_page_n = PAGE_0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (i_IRQ_PEND) begin
                        o_IRQ_TAKEN   = 1'b1;
                        load          = 1'b1;
                        load_opcode   = OP_HARDI;
                        load_injected = 1'b1;
                        state_n       = FETCH_HOLD;
                    end else begin
                        o_BYTE_READY = 1'b1;
                        if (i_BYTE_VALID) begin
                            if (pfx_info[3]) begin
                                pfx_page_n = pfx_info[2:0];
                                state_n    = FETCH_PFX;
                            end else begin
                                load    = 1'b1;
                                state_n = FETCH_HOLD;
                            end
                        end
                    end
                end
                // Second byte is always an opcode, even if it looks like a prefix.
                FETCH_PFX: begin
                    o_BYTE_READY = 1'b1;
                    if (i_BYTE_VALID) begin
                        load       = 1'b1;
                        load_page  = pfx_page;
                        pfx_page_n = PAGE_0;
                        state_n    = FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (i_OP_READY) state_n = FETCH_IDLE;
                end
                default: state_n = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state         <= FETCH_IDLE;
            pfx_page      <= PAGE_0;
            o_OPCODE      <= 8'h00;
            o_OPCODE_PAGE <= PAGE_0;
            o_OP_VALID    <= 1'b0;
            o_OP_INJECTED <= 1'b0;
            o_BOUNDARY    <= 1'b1;
        end else begin
            state      <= state_n;
            pfx_page   <= pfx_page_n;
            o_OP_VALID <= (state_n == FETCH_HOLD);
            o_BOUNDARY <= (state_n == FETCH_IDLE);
            if (load) begin
                o_OPCODE      <= load_opcode;
                o_OPCODE_PAGE <= load_page;
                o_OP_INJECTED <= load_injected;
            end
        end
    end

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Directed self-checking bench for ika87ad_opfetch.
module tb_ika87ad_opfetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       irq_pend;
    logic       irq_taken;
    logic [7:0] opcode;
    logic [2:0] page;
    logic       op_valid;
    logic       op_ready;
    logic       injected;
    logic       boundary;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ika87ad_opfetch dut (
        .i_CLK         (clk),
        .i_RST         (rst),
        .i_FLUSH       (flush),
        .i_BYTE        (byte_in),
        .i_BYTE_VALID  (byte_valid),
        .o_BYTE_READY  (byte_ready),
        .i_IRQ_PEND    (irq_pend),
        .o_IRQ_TAKEN   (irq_taken),
        .o_OPCODE      (opcode),
        .o_OPCODE_PAGE (page),
        .o_OP_VALID    (op_valid),
        .i_OP_READY    (op_ready),
        .o_OP_INJECTED (injected),
        .o_BOUNDARY    (boundary)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic accept();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic chk_op(input string tag, input logic [7:0] op, input logic [2:0] pg,
                          input logic inj);
        chk({tag, "_opcode"}, opcode, op);
        chk({tag, "_page"}, {5'd0, page}, {5'd0, pg});
        chk({tag, "_valid"}, {7'd0, op_valid}, 8'd1);
        chk({tag, "_injected"}, {7'd0, injected}, {7'd0, inj});
        chk({tag, "_boundary"}, {7'd0, boundary}, 8'd0);
    endtask

    logic [7:0] pfx_tab  [5];
    logic [2:0] page_tab [5];

    initial begin
        pfx_tab  = '{8'h48, 8'h60, 8'h64, 8'h70, 8'h74};
        page_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

        rst = 1'b1; flush = 1'b0; byte_in = 8'h54; byte_valid = 1'b1;
        irq_pend = 1'b0; op_ready = 1'b0;
        tick(); tick();
        chk("rst_opcode", opcode, 8'h00);
        chk("rst_page", {5'd0, page}, 8'd0);
        chk("rst_valid", {7'd0, op_valid}, 8'd0);
        chk("rst_injected", {7'd0, injected}, 8'd0);
        chk("rst_boundary", {7'd0, boundary}, 8'd1);
        chk("rst_byte_ready", {7'd0, byte_ready}, 8'd0);
        irq_pend = 1'b1; #1;
        chk("rst_irq_taken", {7'd0, irq_taken}, 8'd0);
        irq_pend = 1'b0; byte_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single-byte opcode
        byte_in = 8'h54; byte_valid = 1'b1; #1;
        chk("single_byte_ready", {7'd0, byte_ready}, 8'd1);
        tick(); byte_valid = 1'b0;
        chk_op("single", 8'h54, 3'd0, 1'b0);
        chk("single_hold_byte_ready", {7'd0, byte_ready}, 8'd0);
        accept();
        chk("single_after_valid", {7'd0, op_valid}, 8'd0);
        chk("single_after_boundary", {7'd0, boundary}, 8'd1);

        // Each prefix with a three-cycle gap before the second byte
        for (int i = 0; i < 5; i++) begin
            send_byte(pfx_tab[i]);
            for (int g = 0; g < 3; g++) begin
                chk("gap_boundary", {7'd0, boundary}, 8'd0);
                chk("gap_valid", {7'd0, op_valid}, 8'd0);
                chk("gap_byte_ready", {7'd0, byte_ready}, 8'd1);
                tick();
            end
            send_byte(8'h6A);
            chk_op("prefixed", 8'h6A, page_tab[i], 1'b0);
            accept();
            chk("prefixed_after_valid", {7'd0, op_valid}, 8'd0);
        end

        // Prefix value as second byte is just an opcode
        send_byte(8'h60);
        send_byte(8'h48);
        chk_op("no_nest", 8'h48, 3'd2, 1'b0);
        accept();
        send_byte(8'h4C);
        chk_op("op_4c", 8'h4C, 3'd0, 1'b0);
        accept();

        // IRQ beats a simultaneous valid byte
        irq_pend = 1'b1; byte_in = 8'h10; byte_valid = 1'b1; #1;
        chk("irq_taken_pulse", {7'd0, irq_taken}, 8'd1);
        chk("irq_byte_ready", {7'd0, byte_ready}, 8'd0);
        tick(); irq_pend = 1'b0; #1;
        chk_op("hardi", 8'h73, 3'd0, 1'b1);
        chk("hardi_hold_irq_taken", {7'd0, irq_taken}, 8'd0);
        accept();
        byte_valid = 1'b1; #1;
        chk("after_hardi_byte_ready", {7'd0, byte_ready}, 8'd1);
        tick(); byte_valid = 1'b0;
        chk_op("after_hardi", 8'h10, 3'd0, 1'b0);
        accept();

        // IRQ ignored during PFX and HOLD, taken once back in IDLE
        send_byte(8'h64);
        irq_pend = 1'b1; #1;
        chk("pfx_irq_taken", {7'd0, irq_taken}, 8'd0);
        chk("pfx_irq_byte_ready", {7'd0, byte_ready}, 8'd1);
        send_byte(8'h20);
        chk_op("pfx_irq", 8'h20, 3'd3, 1'b0);
        chk("hold_irq_taken", {7'd0, irq_taken}, 8'd0);
        accept();
        chk("idle_irq_taken", {7'd0, irq_taken}, 8'd1);
        tick(); irq_pend = 1'b0;
        chk_op("hardi2", 8'h73, 3'd0, 1'b1);
        accept();

        // Flush during PFX discards the prefix
        send_byte(8'h74);
        flush = 1'b1; #1;
        chk("flush_byte_ready", {7'd0, byte_ready}, 8'd0);
        tick(); flush = 1'b0;
        chk("flush_pfx_boundary", {7'd0, boundary}, 8'd1);
        chk("flush_pfx_valid", {7'd0, op_valid}, 8'd0);
        send_byte(8'h21);
        chk_op("after_flush", 8'h21, 3'd0, 1'b0);
        accept();

        // Flush during HOLD drops valid but keeps opcode
        send_byte(8'h33);
        flush = 1'b1; irq_pend = 1'b1; #1;
        chk("flush_irq_taken", {7'd0, irq_taken}, 8'd0);
        tick(); flush = 1'b0; irq_pend = 1'b0;
        chk("flush_hold_valid", {7'd0, op_valid}, 8'd0);
        chk("flush_hold_boundary", {7'd0, boundary}, 8'd1);
        chk("flush_hold_opcode", opcode, 8'h33);

        // Async reset during PFX
        send_byte(8'h70);
        rst = 1'b1; #1;
        chk("midrst_opcode", opcode, 8'h00);
        chk("midrst_valid", {7'd0, op_valid}, 8'd0);
        chk("midrst_boundary", {7'd0, boundary}, 8'd1);
        chk("midrst_byte_ready", {7'd0, byte_ready}, 8'd0);
        tick(); rst = 1'b0;
        send_byte(8'h22);
        chk_op("after_rst", 8'h22, 3'd0, 1'b0);
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
